// File: rtl/cpu_pkg.sv
// Shared CPU definitions: fetch states, IMEM geometry
// and the reset/base addresses of the instruction window.
package cpu_pkg;

  typedef enum logic [1:0] {
    RUN    = 2'd0,
    HALTED = 2'd1,
    FAULT  = 2'd2
  } fetch_state_t;

  localparam logic [31:0] RESET_PC_DFLT  = 32'h0040_0000;
  localparam logic [31:0] IMEM_BASE_DFLT = 32'h0040_0000;
  localparam int          IMEM_WORDS     = 2048;
  localparam logic [31:0] IMEM_BYTES     = 32'(IMEM_WORDS * 4);

endpackage

// File: rtl/fetch_queue.sv
// Small FIFO with flush; head word is presented
// combinationally and reads as zero when empty.
module fetch_queue #(
  parameter int DEPTH = 2,
  parameter int W     = 64,
  localparam int AW   = $clog2(DEPTH),
  localparam int CW   = $clog2(DEPTH + 1)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          push,
  input  logic          pop,
  input  logic          flush,
  input  logic [W-1:0]  wdata,
  output logic [W-1:0]  rdata,
  output logic [CW-1:0] count
);

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] head;
  logic [AW-1:0] tail;

  function automatic logic [AW-1:0] nxt(
    input logic [AW-1:0] p
  );
    return (p == AW'(DEPTH - 1)) ? '0 : p + AW'(1);
  endfunction

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
      for (int i = 0; i < DEPTH; i++)
        mem[i] <= '0;
    end else if (flush) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else begin
      if (push) begin
        mem[tail] <= wdata;
        tail      <= nxt(tail);
      end
      if (pop)
        head <= nxt(head);
      count <= count + CW'(push) - CW'(pop);
    end
  end

  assign rdata = (count != '0) ? mem[head] : '0;

endmodule

// File: rtl/imem_fetch_ctrl.sv
// Instruction fetch controller: owns the PC, reads IMEM,
// buffers words for decode, handles redirect/halt/fault.
module imem_fetch_ctrl
  import cpu_pkg::*;
#(
  parameter logic [31:0] RESET_PC  = RESET_PC_DFLT,
  parameter logic [31:0] IMEM_BASE = IMEM_BASE_DFLT
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic [10:0] imem_addr,
  input  logic [31:0] imem_inst,
  output logic        inst_valid,
  output logic [31:0] inst,
  output logic [31:0] inst_pc,
  input  logic        inst_ready,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  input  logic        halt,
  output logic        fetch_fault
);

  fetch_state_t state;
  fetch_state_t state_n;
  logic [31:0]  pc;
  logic [31:0]  diff;
  logic [63:0]  head;
  logic [1:0]   count;
  logic         pop;
  logic         room;
  logic         pc_ok;
  logic         fetch;

  assign diff      = pc - IMEM_BASE;
  assign imem_addr = diff[12:2];
  assign pc_ok     = (pc[1:0] == 2'b00) && (diff < IMEM_BYTES);
  assign pop       = inst_valid && inst_ready;
  // A slot freed by this cycle's dequeue can be refilled now.
  assign room      = (count != 2'd2) || pop;

  always_comb begin
    state_n = state;
    fetch   = 1'b0;
    if (redirect_valid) begin
      state_n = halt ? HALTED : RUN;
    end else begin
      case (state)
        RUN: begin
          if (halt)
            state_n = HALTED;
          else if (!pc_ok)
            state_n = FAULT;
          else
            fetch = room;
        end
        HALTED: begin
          if (!halt)
            state_n = RUN;
        end
        FAULT:   state_n = FAULT;
        default: state_n = RUN;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= RUN;
      pc          <= RESET_PC;
      fetch_fault <= 1'b0;
    end else begin
      state       <= state_n;
      fetch_fault <= (state_n == FAULT);
      if (redirect_valid)
        pc <= redirect_pc;
      else if (fetch)
        pc <= pc + 32'd4;
    end
  end

  fetch_queue #(
    .DEPTH(2),
    .W    (64)
  ) u_queue (
    .clk  (clk),
    .rst_n(rst_n),
    .push (fetch),
    .pop  (pop),
    .flush(redirect_valid),
    .wdata({imem_inst, pc}),
    .rdata(head),
    .count(count)
  );

  assign inst_valid = (count != 2'd0);
  assign inst       = head[63:32];
  assign inst_pc    = head[31:0];

endmodule

// File: tb/tb_imem_fetch_ctrl.sv
// Bench for imem_fetch_ctrl: directed scenarios plus random
// traffic against a queue-based model of the fetch rules.
module tb_imem_fetch_ctrl;

  localparam logic [31:0] BASE = 32'h0040_0000;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [10:0] imem_addr;
  logic [31:0] imem_inst;
  logic        inst_valid;
  logic [31:0] inst;
  logic [31:0] inst_pc;
  logic        inst_ready = 1'b0;
  logic        redirect_valid = 1'b0;
  logic [31:0] redirect_pc = '0;
  logic        halt = 1'b0;
  logic        fetch_fault;

  logic [31:0] mem [2048];
  int checks = 0;
  int failures = 0;

  logic [31:0] q_inst [$];
  logic [31:0] q_pc [$];
  logic [31:0] m_pc;
  bit          m_fault;
  bit          m_halted;

  always #5 clk = ~clk;

  assign imem_inst = mem[imem_addr];

  imem_fetch_ctrl dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .imem_addr     (imem_addr),
    .imem_inst     (imem_inst),
    .inst_valid    (inst_valid),
    .inst          (inst),
    .inst_pc       (inst_pc),
    .inst_ready    (inst_ready),
    .redirect_valid(redirect_valid),
    .redirect_pc   (redirect_pc),
    .halt          (halt),
    .fetch_fault   (fetch_fault)
  );

  task automatic check(
    input string       tag,
    input logic [31:0] got,
    input logic [31:0] exp
  );
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h t=%0t",
               tag, got, exp, $time);
    end
  endtask

  function automatic bit in_window(input logic [31:0] p);
    return (p % 4 == 0) && (p - BASE < 32'h2000);
  endfunction

  function automatic logic [31:0] word_of(input logic [31:0] p);
    return ((p - BASE) >> 2) & 32'h7ff;
  endfunction

  task automatic model_reset;
    q_inst.delete();
    q_pc.delete();
    m_pc     = BASE;
    m_fault  = 0;
    m_halted = 0;
  endtask

  task automatic model_edge(
    input bit          rdy,
    input bit          rv,
    input logic [31:0] rpc,
    input bit          h
  );
    bit pop;
    pop = (q_pc.size() > 0) && rdy;
    if (rv) begin
      q_inst.delete();
      q_pc.delete();
      m_pc     = rpc;
      m_fault  = 0;
      m_halted = h;
    end else begin
      if (pop) begin
        void'(q_inst.pop_front());
        void'(q_pc.pop_front());
      end
      if (m_fault) begin
      end else if (m_halted) begin
        m_halted = h;
      end else if (h) begin
        m_halted = 1;
      end else if (!in_window(m_pc)) begin
        m_fault = 1;
      end else if (q_pc.size() < 2) begin
        q_inst.push_back(mem[word_of(m_pc)]);
        q_pc.push_back(m_pc);
        m_pc = m_pc + 32'd4;
      end
    end
  endtask

  task automatic step(
    input bit          rdy,
    input bit          rv,
    input logic [31:0] rpc,
    input bit          h
  );
    @(negedge clk);
    inst_ready     = rdy;
    redirect_valid = rv;
    redirect_pc    = rpc;
    halt           = h;
    #1;
    check("valid", inst_valid, q_pc.size() > 0);
    if (q_pc.size() > 0) begin
      check("inst", inst, q_inst[0]);
      check("inst_pc", inst_pc, q_pc[0]);
    end
    check("fault", fetch_fault, m_fault);
    check("addr", {21'b0, imem_addr}, word_of(m_pc));
    @(posedge clk);
    model_edge(rdy, rv, rpc, h);
  endtask

  task automatic do_reset;
    @(negedge clk);
    rst_n          = 1'b0;
    inst_ready     = 1'b0;
    redirect_valid = 1'b0;
    halt           = 1'b0;
    #1;
    check("rst_valid", inst_valid, 0);
    check("rst_inst", inst, 0);
    check("rst_pc", inst_pc, 0);
    check("rst_fault", fetch_fault, 0);
    check("rst_addr", {21'b0, imem_addr}, 0);
    model_reset();
    @(posedge clk);
    #2 rst_n = 1'b1;
  endtask

  function automatic logic [31:0] rand_target;
    int unsigned sel;
    sel = $urandom_range(0, 9);
    case (sel)
      0:       return BASE + ($urandom_range(0, 2047) << 2) + 2;
      1:       return 32'h0040_2000 + ($urandom_range(0, 15) << 2);
      2:       return BASE + 32'h1FF0 + ($urandom_range(0, 3) << 2);
      default: return BASE + ($urandom_range(0, 2047) << 2);
    endcase
  endfunction

  initial begin
    for (int i = 0; i < 2048; i++)
      mem[i] = $urandom;
    model_reset();
    do_reset();

    // sequential fetch then a 6-cycle stall
    repeat (6) step(0, 0, 0, 0);
    #1;
    check("stall_addr", {21'b0, imem_addr}, 32'd2);
    check("stall_pc", inst_pc, BASE);
    check("stall_valid", inst_valid, 1);
    repeat (4) step(1, 0, 0, 0);

    // redirect with a full queue
    repeat (3) step(0, 0, 0, 0);
    step(1, 1, BASE + 32'h100, 0);
    #1;
    check("redir_bubble", inst_valid, 0);
    step(1, 0, 0, 0);
    #1;
    check("redir_pc", inst_pc, BASE + 32'h100);
    check("redir_inst", inst, mem[64]);
    repeat (3) step(1, 0, 0, 0);

    // misaligned redirect faults, later redirect recovers
    step(1, 1, BASE + 32'h102, 0);
    step(1, 0, 0, 0);
    #1;
    check("mis_fault", fetch_fault, 1);
    repeat (4) step(1, 0, 0, 0);
    step(1, 1, BASE, 0);
    repeat (4) step(1, 0, 0, 0);

    // run off the end of the window
    step(1, 1, BASE + 32'h1FF8, 0);
    repeat (6) step(1, 0, 0, 0);
    #1;
    check("end_fault", fetch_fault, 1);

    // halt then resume
    step(1, 1, BASE + 32'h40, 0);
    repeat (3) step(0, 0, 0, 1);
    repeat (3) step(1, 0, 0, 1);
    repeat (3) step(1, 0, 0, 0);

    // asynchronous reset with a full queue
    step(1, 1, BASE, 0);
    repeat (3) step(0, 0, 0, 0);
    do_reset();
    repeat (3) step(1, 0, 0, 0);

    for (int n = 0; n < 3000; n++) begin
      step($urandom_range(0, 9) < 7,
           $urandom_range(0, 19) == 0,
           rand_target(),
           $urandom_range(0, 9) == 0);
    end

    $display("TB_RESULT checks=%0d failures=%0d",
             checks, failures);
    $finish;
  end

endmodule
